// File: rtl/avr_cpu_fetch.sv
// Instruction fetch sequencer for the AVR core.
// Owns the fetch PC, talks to program memory over a single-outstanding
// req/ack handshake, keeps one prefetch word, and presents opcodes to decode.
// A decode-requested RJMP redirects the fetch stream during its first cycle.
module avr_cpu_fetch #(
    parameter int PC_WIDTH     = 11,
    parameter int RESET_VECTOR = 0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pmem_addr,
    output logic                pmem_rd,
    input  logic [15:0]         pmem_rdata,
    input  logic                pmem_ack,
    input  logic                stall,
    input  logic                hold,
    input  logic [11:0]         rjmp,
    output logic [15:0]         opcode,
    output logic                opcode_cycle,
    output logic                opcode_valid,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [31:0]         RST_VEC32 = RESET_VECTOR;
    localparam logic [PC_WIDTH-1:0] RST_PC    = RST_VEC32[PC_WIDTH-1:0];

    logic [PC_WIDTH-1:0] fpc_reg;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] req_addr_reg;
    logic [PC_WIDTH-1:0] pf_addr_reg;
    logic [15:0]         opcode_reg;
    logic [15:0]         pf_data_reg;
    logic                opcode_valid_reg;
    logic                opcode_cycle_reg;
    logic                pf_valid_reg;
    logic                outstanding_reg;
    logic                discard_reg;

    logic                ack_v;
    logic                retire;
    logic                redirect;
    logic                take_ack;
    logic                ack_to_pf;
    logic                issue;
    logic [31:0]         target_full;
    logic [PC_WIDTH-1:0] target;

    // Per-cycle control decisions. An ack frees the request slot in the same
    // cycle, so a new fetch can go out back-to-back -- unless that ack word is
    // being parked in the prefetch buffer, which would leave no room for the
    // next response.
    always_comb begin
        ack_v       = pmem_ack & outstanding_reg;
        retire      = opcode_valid_reg & ~stall & ~(hold & ~opcode_cycle_reg);
        redirect    = opcode_valid_reg & ~stall & hold & ~opcode_cycle_reg;
        take_ack    = ack_v & ~discard_reg & ~redirect
                    & (~opcode_valid_reg | retire) & ~pf_valid_reg;
        ack_to_pf   = ack_v & ~discard_reg & ~redirect & ~take_ack;
        issue       = (~outstanding_reg | ack_v) & ~pf_valid_reg & ~redirect & ~ack_to_pf;
        // Branch target: pc + 1 + sign-extended offset, wrapping at PC_WIDTH bits.
        target_full = {{(32-PC_WIDTH){1'b0}}, pc_reg} + 32'd1 + {{20{rjmp[11]}}, rjmp};
        target      = target_full[PC_WIDTH-1:0];
    end

    // Outputs: decode sees a NOP whenever the opcode register is empty.
    assign pmem_addr    = fpc_reg;
    assign pmem_rd      = issue & ~rst;
    assign opcode       = opcode_valid_reg ? opcode_reg : 16'h0000;
    assign opcode_cycle = opcode_cycle_reg;
    assign opcode_valid = opcode_valid_reg;
    assign pc           = pc_reg;

    // Fetch state, prefetch buffer and opcode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_reg          <= RST_PC;
            pc_reg           <= RST_PC;
            req_addr_reg     <= RST_PC;
            pf_addr_reg      <= RST_PC;
            opcode_reg       <= 16'h0000;
            pf_data_reg      <= 16'h0000;
            opcode_valid_reg <= 1'b0;
            opcode_cycle_reg <= 1'b0;
            pf_valid_reg     <= 1'b0;
            outstanding_reg  <= 1'b0;
            discard_reg      <= 1'b0;
        end else begin
            if (issue) begin
                req_addr_reg    <= fpc_reg;
                fpc_reg         <= fpc_reg + 1'b1;
                outstanding_reg <= 1'b1;
            end else if (ack_v) begin
                outstanding_reg <= 1'b0;
            end

            if (ack_v) begin
                discard_reg <= 1'b0;
            end

            if (redirect) begin
                // First cycle of RJMP: keep the opcode, flush everything in flight.
                opcode_cycle_reg <= 1'b1;
                pf_valid_reg     <= 1'b0;
                fpc_reg          <= target;
                if (outstanding_reg & ~pmem_ack) begin
                    discard_reg <= 1'b1;
                end
            end else begin
                if (retire) begin
                    opcode_cycle_reg <= 1'b0;
                end
                if (retire & pf_valid_reg) begin
                    opcode_reg   <= pf_data_reg;
                    pc_reg       <= pf_addr_reg;
                    pf_valid_reg <= 1'b0;
                end else if (take_ack) begin
                    opcode_reg       <= pmem_rdata;
                    pc_reg           <= req_addr_reg;
                    opcode_valid_reg <= 1'b1;
                end else if (retire) begin
                    opcode_valid_reg <= 1'b0;
                end
                // Later assignment wins: a draining buffer is refilled by the ack.
                if (ack_to_pf) begin
                    pf_data_reg  <= pmem_rdata;
                    pf_addr_reg  <= req_addr_reg;
                    pf_valid_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_avr_cpu_fetch.sv
// Directed bench for avr_cpu_fetch: a latency-programmable program memory
// model plus scripted decode hold/rjmp and stall stimulus.
module tb_avr_cpu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] pmem_addr;
    logic        pmem_rd;
    logic [15:0] pmem_rdata;
    logic        pmem_ack;
    logic        stall = 1'b0;
    logic        hold = 1'b0;
    logic [11:0] rjmp = 12'h000;
    logic [15:0] opcode;
    logic        opcode_cycle;
    logic        opcode_valid;
    logic [10:0] pc;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] mem [0:2047];
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [10:0] paddr = 11'd0;
    logic        inj_ack = 1'b0;

    avr_cpu_fetch #(.PC_WIDTH(11), .RESET_VECTOR(0)) dut (
        .clk(clk), .rst(rst),
        .pmem_addr(pmem_addr), .pmem_rd(pmem_rd),
        .pmem_rdata(pmem_rdata), .pmem_ack(pmem_ack),
        .stall(stall), .hold(hold), .rjmp(rjmp),
        .opcode(opcode), .opcode_cycle(opcode_cycle),
        .opcode_valid(opcode_valid), .pc(pc)
    );

    always #5 clk = ~clk;

    // Program memory: one request at a time, ack after lat cycles.
    always @(posedge clk) begin
        if (pmem_rd) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= pmem_addr;
        end else if (pend && cnt != 0) begin
            cnt <= cnt - 1;
        end else if (pend) begin
            pend <= 1'b0;
        end
    end

    assign pmem_ack   = (pend && cnt == 0) || inj_ack;
    assign pmem_rdata = inj_ack ? 16'hDEAD : mem[paddr];

    task automatic init_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 16'hE000 + 16'(i);
    endtask

    // Reset for two cycles; returns just after release (first fetch cycle).
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b0 || opcode !== 16'h0000 || pc !== 11'd0 || opcode_cycle !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b opcode=%h pc=%h cycle=%b, required 0/0000/000/0",
                     opcode_valid, opcode, pc, opcode_cycle);
        end
        checks++;
        if (pmem_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: pmem_rd=%b, required 0", pmem_rd);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (pmem_rd !== 1'b1 || pmem_addr !== 11'd0) begin
            errors++;
            $display("FAIL reset_first_fetch: rd=%b addr=%h, required 1/000", pmem_rd, pmem_addr);
        end
        $display("test_reset: done");
    endtask

    task automatic test_sequential();
        lat = 1;
        do_reset();
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b0 || pmem_addr !== 11'd1 || pmem_rd !== 1'b1) begin
            errors++;
            $display("FAIL seq_second_cycle: valid=%b addr=%h rd=%b, required 0/001/1",
                     opcode_valid, pmem_addr, pmem_rd);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (opcode_valid !== 1'b1 || pc !== 11'(i) || opcode !== 16'hE000 + 16'(i) ||
                pmem_addr !== 11'(i + 2)) begin
                errors++;
                $display("FAIL seq_word%0d: valid=%b pc=%h opcode=%h addr=%h, required 1/%h/%h/%h",
                         i, opcode_valid, pc, opcode, pmem_addr, 11'(i), 16'hE000 + 16'(i), 11'(i + 2));
            end
        end
        $display("test_sequential: done");
    endtask

    task automatic test_rjmp();
        lat = 1;
        mem[3] = 16'hC005;
        do_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (pc !== 11'd3 || opcode !== 16'hC005) begin
            errors++;
            $display("FAIL rjmp_at3: pc=%h opcode=%h, required 003/C005", pc, opcode);
        end
        hold = 1'b1;
        rjmp = 12'h005;
        #1;
        checks++;
        if (pmem_rd !== 1'b0) begin
            errors++;
            $display("FAIL rjmp_no_rd: pmem_rd=%b, required 0", pmem_rd);
        end
        @(negedge clk);
        checks++;
        if (opcode_cycle !== 1'b1 || pc !== 11'd3 || pmem_addr !== 11'd9 || pmem_rd !== 1'b1) begin
            errors++;
            $display("FAIL rjmp_second: cycle=%b pc=%h addr=%h rd=%b, required 1/003/009/1",
                     opcode_cycle, pc, pmem_addr, pmem_rd);
        end
        hold = 1'b0;
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b0 || opcode_cycle !== 1'b0) begin
            errors++;
            $display("FAIL rjmp_bubble: valid=%b cycle=%b, required 0/0", opcode_valid, opcode_cycle);
        end
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b1 || pc !== 11'd9 || opcode !== 16'hE009) begin
            errors++;
            $display("FAIL rjmp_target: valid=%b pc=%h opcode=%h, required 1/009/E009",
                     opcode_valid, pc, opcode);
        end
        mem[3] = 16'hE003;
        $display("test_rjmp: done");
    endtask

    task automatic test_wrap();
        lat = 1;
        do_reset();
        repeat (2) @(negedge clk);
        hold = 1'b1;
        rjmp = 12'hFFF;
        @(negedge clk);
        checks++;
        if (pmem_addr !== 11'd0 || opcode_cycle !== 1'b1) begin
            errors++;
            $display("FAIL wrap_selfloop: addr=%h cycle=%b, required 000/1", pmem_addr, opcode_cycle);
        end
        hold = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b1 || pc !== 11'd0) begin
            errors++;
            $display("FAIL wrap_selfloop_pc: valid=%b pc=%h, required 1/000", opcode_valid, pc);
        end
        hold = 1'b1;
        rjmp = 12'hFFE;
        @(negedge clk);
        checks++;
        if (pmem_addr !== 11'h7FF) begin
            errors++;
            $display("FAIL wrap_neg: addr=%h, required 7FF", pmem_addr);
        end
        hold = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b1 || pc !== 11'h7FF || opcode !== 16'hE7FF) begin
            errors++;
            $display("FAIL wrap_neg_pc: valid=%b pc=%h opcode=%h, required 1/7FF/E7FF",
                     opcode_valid, pc, opcode);
        end
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b1 || pc !== 11'h000 || opcode !== 16'hE000) begin
            errors++;
            $display("FAIL wrap_roll: valid=%b pc=%h opcode=%h, required 1/000/E000",
                     opcode_valid, pc, opcode);
        end
        $display("test_wrap: done");
    endtask

    task automatic test_stall();
        lat = 1;
        do_reset();
        repeat (7) @(negedge clk);
        stall = 1'b1;
        #1;
        checks++;
        if (pc !== 11'd5 || pmem_rd !== 1'b0) begin
            errors++;
            $display("FAIL stall_enter: pc=%h rd=%b, required 005/0", pc, pmem_rd);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (pc !== 11'd5 || opcode !== 16'hE005 || pmem_rd !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: pc=%h opcode=%h rd=%b, required 005/E005/0",
                         k, pc, opcode, pmem_rd);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b1 || pc !== 11'd6 || opcode !== 16'hE006 ||
            pmem_rd !== 1'b1 || pmem_addr !== 11'd7) begin
            errors++;
            $display("FAIL stall_drain: valid=%b pc=%h opcode=%h rd=%b addr=%h, required 1/006/E006/1/007",
                     opcode_valid, pc, opcode, pmem_rd, pmem_addr);
        end
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_bubble: valid=%b, required 0", opcode_valid);
        end
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b1 || pc !== 11'd7 || opcode !== 16'hE007) begin
            errors++;
            $display("FAIL stall_next: valid=%b pc=%h opcode=%h, required 1/007/E007",
                     opcode_valid, pc, opcode);
        end
        $display("test_stall: done");
    endtask

    task automatic test_latency();
        lat = 4;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (opcode_valid !== 1'b0 || opcode !== 16'h0000 || pmem_rd !== (k == 4)) begin
                errors++;
                $display("FAIL lat_wait0_%0d: valid=%b opcode=%h rd=%b, required 0/0000/%b",
                         k, opcode_valid, opcode, pmem_rd, (k == 4));
            end
        end
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b1 || pc !== 11'd0 || opcode !== 16'hE000 || pmem_rd !== 1'b0) begin
            errors++;
            $display("FAIL lat_word0: valid=%b pc=%h opcode=%h rd=%b, required 1/000/E000/0",
                     opcode_valid, pc, opcode, pmem_rd);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (opcode_valid !== 1'b0 || opcode !== 16'h0000 || pmem_rd !== (k == 3)) begin
                errors++;
                $display("FAIL lat_wait1_%0d: valid=%b opcode=%h rd=%b, required 0/0000/%b",
                         k, opcode_valid, opcode, pmem_rd, (k == 3));
            end
        end
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b1 || pc !== 11'd1 || opcode !== 16'hE001) begin
            errors++;
            $display("FAIL lat_word1: valid=%b pc=%h opcode=%h, required 1/001/E001",
                     opcode_valid, pc, opcode);
        end
        $display("test_latency: done");
    endtask

    task automatic test_reset_mid();
        lat = 4;
        do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (pmem_rd !== 1'b0 || opcode_valid !== 1'b0 || pc !== 11'd0) begin
            errors++;
            $display("FAIL rstmid_enter: rd=%b valid=%b pc=%h, required 0/0/000",
                     pmem_rd, opcode_valid, pc);
        end
        repeat (5) @(negedge clk);
        lat = 1;
        rst = 1'b0;
        inj_ack = 1'b1;
        #1;
        checks++;
        if (pmem_rd !== 1'b1 || pmem_addr !== 11'd0) begin
            errors++;
            $display("FAIL rstmid_first: rd=%b addr=%h, required 1/000", pmem_rd, pmem_addr);
        end
        @(negedge clk);
        inj_ack = 1'b0;
        checks++;
        if (opcode_valid !== 1'b0 || opcode !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_late_ack: valid=%b opcode=%h, required 0/0000", opcode_valid, opcode);
        end
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b1 || pc !== 11'd0 || opcode !== 16'hE000) begin
            errors++;
            $display("FAIL rstmid_refetch: valid=%b pc=%h opcode=%h, required 1/000/E000",
                     opcode_valid, pc, opcode);
        end
        $display("test_reset_mid: done");
    endtask

    initial begin
        init_mem();
        test_reset();
        test_sequential();
        test_rjmp();
        test_wrap();
        test_stall();
        test_latency();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
